// File: rtl/ibex_csr_access_pkg.sv
// Shared definitions for the CSR access initiator.
//   csr_op_e      : request operation encoding (read, write, set bits, clear bits)
//   ctrl_state_t  : access FSM state type, with its state constants
package ibex_csr_access_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t ST_IDLE  = 2'd0;
    localparam ctrl_state_t ST_READ  = 2'd1;
    localparam ctrl_state_t ST_WRITE = 2'd2;
    localparam ctrl_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/ibex_csr_scrubber.sv
// Background integrity scrubber: walks a pointer over all attached CSRs,
// one per enabled cycle, and reports the sampled integrity error.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   en_i             : scrub this cycle (controller idle, no request pending)
//   csr_rd_error_i   : per-CSR integrity error
//   err_o            : integrity error of the CSR pointed at, qualified by en_i
module ibex_csr_scrubber #(
    parameter int unsigned NumCsr = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [NumCsr-1:0] csr_rd_error_i,
    output logic              err_o
);

    localparam int unsigned PtrW = (NumCsr > 1) ? $clog2(NumCsr) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            if (ptr_q == PtrW'(NumCsr - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign err_o = en_i & csr_rd_error_i[ptr_q];

endmodule

// File: rtl/ibex_csr_access_ctrl.sv
// CSR access initiator: accepts read/write/set/clear requests, performs the
// read-modify-write on the addressed CSR and returns its previous value.
//   req_*          : request handshake (op, addr, operand)
//   rsp_*          : response handshake (old value, error)
//   csr_wr_en_o    : one-hot write strobe, high for the single WRITE cycle
//   csr_wr_data_o  : shared write data, holds its last value outside WRITE
//   csr_rd_data_i  : packed read data, CSR k at [k*Width +: Width]
//   csr_rd_error_i : per-CSR integrity error
//   alert_o        : sticky integrity alert, cleared by alert_clr_i
module ibex_csr_access_ctrl
    import ibex_csr_access_pkg::*;
#(
    parameter int unsigned Width  = 32,
    parameter int unsigned NumCsr = 8,
    parameter int unsigned AddrW  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [AddrW-1:0]        req_addr_i,
    input  logic [Width-1:0]        req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [Width-1:0]        rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic [NumCsr-1:0]       csr_wr_en_o,
    output logic [Width-1:0]        csr_wr_data_o,
    input  logic [NumCsr*Width-1:0] csr_rd_data_i,
    input  logic [NumCsr-1:0]       csr_rd_error_i,
    output logic                    alert_o,
    input  logic                    alert_clr_i
);

    ctrl_state_t       state_q, state_d;
    csr_op_e           op_q, op_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [Width-1:0]  operand_q, operand_d;
    logic [Width-1:0]  rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [NumCsr-1:0] wr_en_q, wr_en_d;
    logic [Width-1:0]  wr_data_q, wr_data_d;
    logic              alert_q, alert_d;

    logic              addr_ok;
    logic [Width-1:0]  old_val;
    logic              old_err;
    logic [Width-1:0]  new_val;
    logic              need_write;
    logic              scrub_en;
    logic              scrub_err;
    logic              alert_set;

    // Select the addressed CSR by comparison rather than a computed part-select
    // so an out-of-range address never indexes outside the packed bus.
    always_comb begin
        old_val = '0;
        old_err = 1'b0;
        addr_ok = (32'(addr_q) < NumCsr);
        for (int unsigned k = 0; k < NumCsr; k++) begin
            if (32'(addr_q) == k) begin
                old_val = csr_rd_data_i[k*Width +: Width];
                old_err = csr_rd_error_i[k];
            end
        end
    end

    always_comb begin
        new_val    = old_val;
        need_write = 1'b0;
        unique case (op_q)
            CSR_OP_READ:  begin
                new_val    = old_val;
                need_write = 1'b0;
            end
            CSR_OP_WRITE: begin
                new_val    = operand_q;
                need_write = 1'b1;
            end
            CSR_OP_SET:   begin
                new_val    = old_val | operand_q;
                need_write = (operand_q != '0);
            end
            CSR_OP_CLEAR: begin
                new_val    = old_val & ~operand_q;
                need_write = (operand_q != '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        operand_d   = operand_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        wr_en_d     = '0;
        wr_data_d   = wr_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d      = csr_op_e'(req_op_i);
                    addr_d    = req_addr_i;
                    operand_d = req_wdata_i;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (!addr_ok) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    rdata_d = old_val;
                    err_d   = old_err;
                    if (old_err || !need_write) begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        // Strobe and data registered here so both appear
                        // together for exactly the WRITE cycle.
                        wr_en_d   = NumCsr'(1) << addr_q;
                        wr_data_d = new_val;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign scrub_en = (state_q == ST_IDLE) && !req_valid_i;

    ibex_csr_scrubber #(
        .NumCsr(NumCsr)
    ) u_scrubber (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (scrub_en),
        .csr_rd_error_i (csr_rd_error_i),
        .err_o          (scrub_err)
    );

    // Set takes priority over clear so a concurrent error is never lost.
    always_comb begin
        alert_set = scrub_err | ((state_q == ST_READ) & addr_ok & old_err);
        alert_d   = alert_q;
        if (alert_set) begin
            alert_d = 1'b1;
        end else if (alert_clr_i) begin
            alert_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            op_q        <= CSR_OP_READ;
            addr_q      <= '0;
            operand_q   <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            wr_en_q     <= '0;
            wr_data_q   <= '0;
            alert_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            operand_q   <= operand_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            alert_q     <= alert_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_error_o   = err_q;
    assign csr_wr_en_o   = wr_en_q;
    assign csr_wr_data_o = wr_data_q;
    assign alert_o       = alert_q;

endmodule

// File: tb/tb_ibex_csr_access_ctrl.sv
// Self-checking bench for ibex_csr_access_ctrl (NumCsr=8, AddrW=4 so that
// out-of-range addresses are reachable). The bench models the CSR array and
// predicts every response from the access rules.
module tb_ibex_csr_access_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned AW = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [1:0]      req_op_i;
    logic [AW-1:0]   req_addr_i;
    logic [W-1:0]    req_wdata_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [W-1:0]    rsp_rdata_o;
    logic            rsp_error_o;
    logic [N-1:0]    csr_wr_en_o;
    logic [W-1:0]    csr_wr_data_o;
    logic [N*W-1:0]  csr_rd_data_i;
    logic [N-1:0]    csr_rd_error_i;
    logic            alert_o;
    logic            alert_clr_i;

    logic [W-1:0]    mem [N];
    logic [N-1:0]    errv;
    logic [W-1:0]    last_wr_data;

    int nvec = 0;
    int nbad = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < N; k++) csr_rd_data_i[k*W +: W] = mem[k];
        csr_rd_error_i = errv;
    end

    ibex_csr_access_ctrl #(
        .Width(W),
        .NumCsr(N),
        .AddrW(AW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_error_o    (rsp_error_o),
        .csr_wr_en_o    (csr_wr_en_o),
        .csr_wr_data_o  (csr_wr_data_o),
        .csr_rd_data_i  (csr_rd_data_i),
        .csr_rd_error_i (csr_rd_error_i),
        .alert_o        (alert_o),
        .alert_clr_i    (alert_clr_i)
    );

    // Drives one request from a negedge (DUT idle) and observes it until the
    // response. Cycle 1 is the first cycle after the accept edge. Observed
    // writes are applied to the modelled CSR array.
    task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [W-1:0] wd,
                           output logic [W-1:0] o_rdata, output logic o_err,
                           output int o_rsp_cyc, output int o_wr_cnt,
                           output logic [N-1:0] o_wr_en, output logic [W-1:0] o_wr_data,
                           output int o_wr_cyc);
        int cyc;
        o_rdata = '0; o_err = 1'b0; o_rsp_cyc = -1; o_wr_cnt = 0;
        o_wr_en = '0; o_wr_data = '0; o_wr_cyc = -1;
        req_op_i = op; req_addr_i = addr; req_wdata_i = wd; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            if (csr_wr_en_o != '0) begin
                o_wr_cnt++;
                o_wr_en = csr_wr_en_o; o_wr_data = csr_wr_data_o; o_wr_cyc = cyc;
            end
            if (rsp_valid_o) begin
                o_rdata = rsp_rdata_o; o_err = rsp_error_o; o_rsp_cyc = cyc;
                break;
            end
            @(negedge clk_i);
            cyc++;
        end
        if (o_wr_cnt == 1) begin
            for (int k = 0; k < N; k++) if (o_wr_en[k]) mem[k] = o_wr_data;
            last_wr_data = o_wr_data;
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0;
        req_wdata_i = '0; rsp_ready_i = 1'b1; alert_clr_i = 1'b0; errv = '0;
        last_wr_data = '0;
        for (int k = 0; k < N; k++) mem[k] = $urandom;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        nvec++; if (req_ready_o !== 1'b1) begin nbad++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
        nvec++; if (rsp_valid_o !== 1'b0) begin nbad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        nvec++; if (rsp_rdata_o !== '0) begin nbad++; $display("FAIL reset_rdata got %h want 0", rsp_rdata_o); end
        nvec++; if (rsp_error_o !== 1'b0) begin nbad++; $display("FAIL reset_error got %b want 0", rsp_error_o); end
        nvec++; if (csr_wr_en_o !== '0) begin nbad++; $display("FAIL reset_wr_en got %b want 0", csr_wr_en_o); end
        nvec++; if (csr_wr_data_o !== '0) begin nbad++; $display("FAIL reset_wr_data got %h want 0", csr_wr_data_o); end
        nvec++; if (alert_o !== 1'b0) begin nbad++; $display("FAIL reset_alert got %b want 0", alert_o); end
    endtask

    // Directed table first, then random requests; expectations follow the
    // access rules applied to the modelled CSR contents.
    task automatic test_rmw(input int n_rand);
        logic [1:0]    dop [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
        logic [AW-1:0] dad [5] = '{4'd2, 4'd1, 4'd1, 4'd0, 4'd9};
        logic [W-1:0]  dwd [5] = '{32'hDEADBEEF, 32'h0000FF00, 32'h00000001, 32'h0, 32'h5};
        logic [1:0] op; logic [AW-1:0] addr; logic [W-1:0] wd;
        logic [W-1:0] e_old, e_new; logic e_err, e_wr; int e_rsp;
        logic [W-1:0] o_rdata, o_wr_data; logic o_err; int o_rsp, o_cnt, o_wcyc;
        logic [N-1:0] o_wen;
        mem[2] = 32'h0;
        mem[1] = 32'h12340001;
        for (int i = 0; i < 5 + n_rand; i++) begin
            if (i < 5) begin
                op = dop[i]; addr = dad[i]; wd = dwd[i];
            end else begin
                op = 2'($urandom_range(0, 3));
                addr = AW'($urandom_range(0, 9));
                wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            end
            e_err = (addr >= N);
            e_old = e_err ? 32'h0 : mem[addr];
            if (!e_err) e_err = errv[addr];
            case (op)
                2'b01:   e_new = wd;
                2'b10:   e_new = e_old | wd;
                2'b11:   e_new = e_old & ~wd;
                default: e_new = e_old;
            endcase
            e_wr  = !e_err && (op == 2'b01 || (op[1] && wd != 0));
            e_rsp = e_wr ? 3 : 2;
            run_req(op, addr, wd, o_rdata, o_err, o_rsp, o_cnt, o_wen, o_wr_data, o_wcyc);
            nvec++; if (o_rdata !== e_old) begin nbad++; $display("FAIL rmw_rdata[%0d] got %h want %h", i, o_rdata, e_old); end
            nvec++; if (o_err !== e_err) begin nbad++; $display("FAIL rmw_error[%0d] got %b want %b", i, o_err, e_err); end
            nvec++; if (o_rsp !== e_rsp) begin nbad++; $display("FAIL rmw_rsp_latency[%0d] got %0d want %0d", i, o_rsp, e_rsp); end
            nvec++; if (o_cnt !== (e_wr ? 1 : 0)) begin nbad++; $display("FAIL rmw_wr_count[%0d] got %0d want %0d", i, o_cnt, e_wr ? 1 : 0); end
            if (e_wr) begin
                nvec++; if (o_wen !== (N'(1) << addr)) begin nbad++; $display("FAIL rmw_wr_en[%0d] got %b want %b", i, o_wen, N'(1) << addr); end
                nvec++; if (o_wr_data !== e_new) begin nbad++; $display("FAIL rmw_wr_data[%0d] got %h want %h", i, o_wr_data, e_new); end
                nvec++; if (o_wcyc !== 2) begin nbad++; $display("FAIL rmw_wr_latency[%0d] got %0d want 2", i, o_wcyc); end
            end else begin
                nvec++; if (csr_wr_data_o !== last_wr_data) begin nbad++; $display("FAIL rmw_wr_data_hold[%0d] got %h want %h", i, csr_wr_data_o, last_wr_data); end
            end
            nvec++; if (alert_o !== 1'b0) begin nbad++; $display("FAIL rmw_alert[%0d] got %b want 0", i, alert_o); end
            nvec++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin nbad++; $display("FAIL rmw_return_idle[%0d] got valid=%b ready=%b want 0 1", i, rsp_valid_o, req_ready_o); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e_old;
        bit seen = 0;
        e_old = mem[3];
        rsp_ready_i = 1'b0;
        req_op_i = 2'b00; req_addr_i = 4'd3; req_wdata_i = '0; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rsp_valid_o) seen = 1; else @(negedge clk_i);
        end
        nvec++; if (!seen) begin nbad++; $display("FAIL bp_rsp_timeout got none want rsp_valid"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            nvec++; if (rsp_valid_o !== 1'b1) begin nbad++; $display("FAIL bp_valid[%0d] got %b want 1", i, rsp_valid_o); end
            nvec++; if (rsp_rdata_o !== e_old) begin nbad++; $display("FAIL bp_rdata[%0d] got %h want %h", i, rsp_rdata_o, e_old); end
            nvec++; if (req_ready_o !== 1'b0) begin nbad++; $display("FAIL bp_ready[%0d] got %b want 0", i, req_ready_o); end
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        nvec++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin nbad++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", rsp_valid_o, req_ready_o); end
    endtask

    task automatic test_scrub();
        logic [W-1:0] o_rdata, o_wr_data, e_old; logic o_err; int o_rsp, o_cnt, o_wcyc;
        logic [N-1:0] o_wen;
        bit seen = 0;
        errv[5] = 1'b1;
        for (int i = 0; i < N + 1 && !seen; i++) begin
            @(negedge clk_i);
            if (alert_o) seen = 1;
        end
        nvec++; if (!seen) begin nbad++; $display("FAIL scrub_alert_timeout got 0 want 1 within %0d cycles", N + 1); end
        repeat (3) @(negedge clk_i);
        nvec++; if (alert_o !== 1'b1) begin nbad++; $display("FAIL scrub_alert_sticky got %b want 1", alert_o); end
        e_old = mem[5];
        run_req(2'b01, 4'd5, 32'hCAFEF00D, o_rdata, o_err, o_rsp, o_cnt, o_wen, o_wr_data, o_wcyc);
        nvec++; if (o_err !== 1'b1) begin nbad++; $display("FAIL scrub_write_error got %b want 1", o_err); end
        nvec++; if (o_cnt !== 0) begin nbad++; $display("FAIL scrub_write_no_wr got %0d want 0", o_cnt); end
        nvec++; if (o_rdata !== e_old) begin nbad++; $display("FAIL scrub_write_rdata got %h want %h", o_rdata, e_old); end
        errv = '0;
        alert_clr_i = 1'b1;
        @(negedge clk_i);
        alert_clr_i = 1'b0;
        nvec++; if (alert_o !== 1'b0) begin nbad++; $display("FAIL scrub_alert_clear got %b want 0", alert_o); end
        repeat (N + 2) @(negedge clk_i);
        nvec++; if (alert_o !== 1'b0) begin nbad++; $display("FAIL scrub_alert_quiet got %b want 0", alert_o); end
    endtask

    task automatic test_reset_mid_write();
        req_op_i = 2'b01; req_addr_i = 4'd4; req_wdata_i = 32'h0BADF00D; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        nvec++; if (csr_wr_en_o !== 8'b0001_0000) begin nbad++; $display("FAIL rst_mid_pre_wr_en got %b want 00010000", csr_wr_en_o); end
        #1 rst_ni = 1'b0;
        #1;
        nvec++; if (csr_wr_en_o !== '0) begin nbad++; $display("FAIL rst_mid_wr_en got %b want 0", csr_wr_en_o); end
        nvec++; if (req_ready_o !== 1'b1) begin nbad++; $display("FAIL rst_mid_idle got ready=%b want 1", req_ready_o); end
        nvec++; if (rsp_valid_o !== 1'b0 || alert_o !== 1'b0) begin nbad++; $display("FAIL rst_mid_outputs got valid=%b alert=%b want 0 0", rsp_valid_o, alert_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        nvec++; if (csr_wr_en_o !== '0 || rsp_valid_o !== 1'b0) begin nbad++; $display("FAIL rst_mid_residual got wr_en=%b valid=%b want 0 0", csr_wr_en_o, rsp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_rmw(60);
        test_backpressure();
        test_scrub();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/ibex_csr_access_ctrl.md
Name: ibex_csr_access_ctrl

Overview:
Initiator side of the per-register CSR write/read-check interface. Accepts CSR access requests from the core (read, write, set, clear) with a valid/ready handshake, performs the read-modify-write, and returns the old value. Drives each register's write enable and write data, and samples each register's read data and integrity error. While idle, a background scrubber polls every register's integrity error and raises a sticky alert.

Parameters:
Width, 32, CSR data width in bits.
NumCsr, 8, number of attached CSR instances (2..256).
AddrW, 3, request address width; must satisfy 2**AddrW >= NumCsr.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_op_i  in  2  00 read, 01 write, 10 set bits, 11 clear bits
req_addr_i  in  AddrW  CSR index
req_wdata_i  in  Width  operand
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_rdata_o  out  Width  CSR value before the access
rsp_error_o  out  1  illegal address or integrity error
csr_wr_en_o  out  NumCsr  one-hot write strobe
csr_wr_data_o  out  Width  write data, shared by all CSRs
csr_rd_data_i  in  NumCsr*Width  packed read data; CSR k occupies bits [k*Width +: Width]
csr_rd_error_i  in  NumCsr  per-CSR integrity error
alert_o  out  1  sticky integrity alert
alert_clr_i  in  1  clears alert_o

Behaviour:
- Reset values: FSM IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_error_o=0; csr_wr_en_o=0; csr_wr_data_o=0; alert_o=0; scrub pointer=0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready_o=1 only in this state. On req_valid_i, latch op, addr and operand, then go to READ.
- READ (one cycle):
  - addr >= NumCsr: capture rdata=0 and error=1, go to RESP.
  - Otherwise capture old=csr_rd_data_i[addr] and err=csr_rd_error_i[addr].
  - Compute new value: write gives operand; set gives old|operand; clear gives old&~operand.
  - need_write = (op==write) or (op is set/clear and operand != 0).
  - err=1 or need_write=0: go to RESP. Otherwise go to WRITE.
- WRITE (one cycle): csr_wr_en_o[addr]=1 and csr_wr_data_o=new, both registered. Go to RESP.
- RESP: rsp_valid_o=1, holding the captured old value and error, until rsp_ready_i. Then return to IDLE; rsp_valid_o drops the following cycle.
- Latency, accept cycle = 0:
  - Read: rsp_valid_o at cycle 2.
  - Write: wr_en at cycle 2, rsp_valid_o at cycle 3.
  - Back-to-back throughput: one request per 3 or 4 cycles.
- csr_wr_en_o is zero outside WRITE and is never multi-hot. csr_wr_data_o keeps its last value outside WRITE.
- Integrity error during READ: no write issued, rsp_error_o=1, alert_o set.
- Scrubber:
  - Active each cycle the FSM is in IDLE and req_valid_i=0.
  - Samples csr_rd_error_i[ptr]; if 1, sets alert_o.
  - ptr increments and wraps from NumCsr-1 to 0.
  - ptr holds while a request is in flight.
- alert_o is sticky. alert_clr_i clears it. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: FSM returns to IDLE asynchronously and no residual wr_en is emitted; rsp_valid_o and alert_o are cleared.

Decomposition:
- Shared package ibex_csr_access_pkg holds:
  - typedef csr_op_e {CSR_OP_READ=2'b00, CSR_OP_WRITE=2'b01, CSR_OP_SET=2'b10, CSR_OP_CLEAR=2'b11}.
  - FSM state typedef.
- One sub-module, ibex_csr_scrubber: owns the pointer, wrap logic and error-sample output. The alert flop stays in the top.

Test Plan:
- Write 0xDEADBEEF to addr 2 with CSR 2 holding 0x0 -> csr_wr_en_o=0b00000100 for exactly one cycle at cycle 2, wr_data 0xDEADBEEF; rsp_rdata_o=0x0, rsp_error_o=0 at cycle 3.
- Set 0x0000FF00 on addr 1 holding 0x12340001 -> wr_data 0x1234FF01; rsp_rdata_o=0x12340001. Then clear 0x00000001 -> wr_data 0x1234FF00.
- Set with operand 0 on addr 0 -> no wr_en pulse; rsp_valid_o at cycle 2 with the current value.
- Request at addr 9 with NumCsr=8 -> rsp_error_o=1, rsp_rdata_o=0, no wr_en pulse, alert_o stays 0.
- Force csr_rd_error_i[5]=1 while idle -> alert_o=1 within NumCsr+1 cycles and stays 1. Then a write to addr 5 -> rsp_error_o=1 with no wr_en. Then alert_clr_i for one cycle with the error removed -> alert_o=0.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o=0. Assert rst_ni=0 mid-WRITE -> csr_wr_en_o=0 immediately, state IDLE.
